// File: rtl/cell_exerciser.sv
// cell_exerciser: exhaustive stimulus engine for standard-cell test structures.
// Applies every input vector to one cell-under-test and waits a settle time.
// It then samples the synchronised cell outputs into a MISR and counts the
// samples where cell_out[0] is high.
// Build option: define GRAY_ORDER_EN to walk vectors in Gray order (binary otherwise).
module cell_exerciser #(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        n_inputs,
    output logic [N_IN-1:0]   cell_in,
    input  logic [N_OUT-1:0]  cell_out,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     ones_count,
    output logic [N_IN:0]     vec_idx
);

    localparam int unsigned IDX_W = N_IN + 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [IDX_W-1:0]   last_idx;
    logic [N_OUT-1:0]   sync1;
    logic [N_OUT-1:0]   sync2;

    logic [4:0]         n_clamped_c;
    logic [IDX_W-1:0]   last_idx_c;
    logic [N_IN-1:0]    pattern_c;
    logic [SIG_W-1:0]   sig_next_c;

    // Two-flop synchroniser on the asynchronous cell outputs, always running.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= cell_out;
            sync2 <= sync1;
        end
    end

    // Clamp the requested input count and derive the final vector index.
    always_comb begin
        n_clamped_c = n_inputs;
        if (32'(n_inputs) > N_IN) begin
            n_clamped_c = 5'(N_IN);
        end
        last_idx_c = (IDX_W'(1) << n_clamped_c) - IDX_W'(1);
    end

    // Stimulus pattern for the current vector index; upper bits stay zero
    // because vec_idx never exceeds 2^n-1.
    always_comb begin
        pattern_c = vec_idx[N_IN-1:0];
`ifdef GRAY_ORDER_EN
        pattern_c = vec_idx[N_IN-1:0] ^ (vec_idx[N_IN-1:0] >> 1);
`endif
    end

    // Next MISR value folding in the synchronised outputs.
    always_comb begin
        sig_next_c = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(sync2);
    end

    // Run sequencer with registered outputs; abort overrides every busy state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            last_idx   <= '0;
            cell_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= '1;
            ones_count <= '0;
            vec_idx    <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state   <= S_IDLE;
                cell_in <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            last_idx   <= last_idx_c;
                            signature  <= '1;
                            ones_count <= '0;
                            vec_idx    <= '0;
                            busy       <= 1'b1;
                            state      <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        cell_in    <= pattern_c;
                        settle_cnt <= CNT_W'(SETTLE - 1);
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state <= S_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end
                    end
                    S_SAMPLE: begin
                        signature  <= sig_next_c;
                        ones_count <= ones_count + IDX_W'(sync2[0]);
                        if (vec_idx == last_idx) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            vec_idx <= vec_idx + IDX_W'(1);
                            state   <= S_APPLY;
                        end
                    end
                    S_DONE: begin
                        cell_in <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cell_exerciser.sv
// Self-checking bench for cell_exerciser: directed scenarios plus random runs
// against a vector-level reference model (exhaustive walk, MISR, ones count).
module tb_cell_exerciser;

    localparam int unsigned N_IN  = 16;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned S     = 4;
    localparam int unsigned IDX_W = N_IN + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [4:0]        n_inputs;
    logic [N_IN-1:0]   cell_in;
    logic [N_OUT-1:0]  cell_out;
    logic              busy;
    logic              done;
    logic [15:0]       signature;
    logic [N_IN:0]     ones_count;
    logic [N_IN:0]     vec_idx;

    // Synthetic cell: parity of masked inputs, OR of masked inputs, plus constant.
    logic [N_IN-1:0]   ma;
    logic [N_IN-1:0]   mb;
    logic [1:0]        cc;

    int checks = 0;
    int errors = 0;
    bit saw_done;
    bit gray_ok;
    logic [N_IN-1:0] last_pat;

    cell_exerciser #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(S), .SIG_W(16), .POLY(16'h1021)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start     (start),
        .abort     (abort),
        .n_inputs  (n_inputs),
        .cell_in   (cell_in),
        .cell_out  (cell_out),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .ones_count(ones_count),
        .vec_idx   (vec_idx)
    );

    always #5 clk = ~clk;

    assign cell_out = {(|(cell_in & mb)) ^ cc[1], (^(cell_in & ma)) ^ cc[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_IN-1:0] pattern(input int i);
`ifdef GRAY_ORDER_EN
        return N_IN'(i ^ (i >> 1));
`else
        return N_IN'(i);
`endif
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] o);
        int unsigned v;
        v = (int'(s) * 2) % 65536;
        if (s >= 16'h8000) v = v ^ 32'h1021;
        v = v ^ int'(o);
        return 16'(v);
    endfunction

    // Expected signature and ones count after the first nv vectors of a run.
    task automatic model(input int nv, output logic [15:0] sig, output int ones);
        logic [N_IN-1:0] p;
        logic o0, o1;
        sig  = 16'hFFFF;
        ones = 0;
        for (int i = 0; i < nv; i++) begin
            p  = pattern(i);
            o0 = (^(p & ma)) ^ cc[0];
            o1 = (|(p & mb)) ^ cc[1];
            ones += int'(o0);
            sig = misr(sig, {o1, o0});
        end
    endtask

    // Full run: checks latency, per-vector stimulus, results and return to idle.
    task automatic do_run(input int nin, input int expn, input string tag);
        int cyc;
        int vcount;
        int k;
        logic [15:0] esig;
        int eones;
        bit pat_ok;
        logic [N_IN-1:0] prev;
        vcount = 1 << expn;
        model(vcount, esig, eones);
        pat_ok  = 1'b1;
        gray_ok = 1'b1;
        prev    = '0;
        n_inputs = 5'(nin);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_first"}, 64'(busy), 64'(1));
        chk({tag, "_idx_first"}, 64'(vec_idx), 64'(0));
        while (done !== 1'b1 && cyc < vcount * (S + 2) + 20) begin
            if (cyc >= 4 && (cyc - 4) % (S + 2) == 0 && (cyc - 4) / (S + 2) < vcount) begin
                k = (cyc - 4) / (S + 2);
                if (cell_in !== pattern(k)) pat_ok = 1'b0;
                if (k > 0 && $countones(cell_in ^ prev) != 1) gray_ok = 1'b0;
                prev     = cell_in;
                last_pat = cell_in;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(vcount * (S + 2) + 1));
        chk({tag, "_patterns"}, 64'(pat_ok), 64'(1));
        chk({tag, "_sig"}, 64'(signature), 64'(esig));
        chk({tag, "_ones"}, 64'(ones_count), 64'(eones));
        chk({tag, "_last_idx"}, 64'(vec_idx), 64'(vcount - 1));
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_idle_cellin"}, 64'(cell_in), 64'(0));
    endtask

    task automatic wait_vec(input int target, input string tag);
        int b;
        b = 0;
        while (vec_idx !== IDX_W'(target) && b < 4000) begin
            @(negedge clk);
            b++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk({tag, "_reach"}, 64'(vec_idx), 64'(target));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cellin"}, 64'(cell_in), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_sig"}, 64'(signature), 64'(16'hFFFF));
        chk({tag, "_ones"}, 64'(ones_count), 64'(0));
        chk({tag, "_idx"}, 64'(vec_idx), 64'(0));
    endtask

    initial begin
        logic [15:0] esig;
        int eones;
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_inputs = '0;
        ma = '0; mb = '0; cc = '0;
        saw_done = 1'b0;
        last_pat = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // Loopback of cell_in[0], n=3
        ma = 16'h0001; mb = '0; cc = 2'b00;
        do_run(3, 3, "loop3");
        chk("loop3_ones4", 64'(ones_count), 64'(4));

        // Reset in the middle of a settle window
        ma = 16'h0003; mb = 16'h0004; cc = 2'b00;
        n_inputs = 5'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'(0));
        chk("midrst_still_idle", 64'(busy), 64'(0));

        // Zero inputs: single all-zero vector, constant outputs
        ma = '0; mb = '0; cc = 2'b11;
        do_run(0, 0, "n0");
        chk("n0_sig_const", 64'(signature), 64'(16'hEFDC));
        chk("n0_ones1", 64'(ones_count), 64'(1));

        // Vector ordering over n=4
        ma = 16'h0005; mb = 16'h000A; cc = 2'b01;
        do_run(4, 4, "order4");
`ifdef GRAY_ORDER_EN
        chk("order4_gray_step", 64'(gray_ok), 64'(1));
        chk("order4_last", 64'(last_pat), 64'(4'b1000));
`else
        chk("order4_last", 64'(last_pat), 64'(4'b1111));
`endif

        // Random cells and input counts
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(0, 5));
            ma = N_IN'($urandom);
            mb = N_IN'($urandom);
            cc = 2'($urandom);
            do_run(n, n, "rand");
        end

        // Abort at vector 5, then restart from zero
        ma = N_IN'($urandom); mb = N_IN'($urandom); cc = 2'($urandom);
        model(5, esig, eones);
        n_inputs = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        wait_vec(5, "abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_cellin", 64'(cell_in), 64'(0));
        chk("abort_idx", 64'(vec_idx), 64'(5));
        chk("abort_sig", 64'(signature), 64'(esig));
        chk("abort_ones", 64'(ones_count), 64'(eones));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'(0));
        chk("abort_idx_hold", 64'(vec_idx), 64'(5));
        do_run(4, 4, "restart");

        // Start together with abort in IDLE stays idle
        n_inputs = 5'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(0));

        // Oversized n_inputs clamps to N_IN; mid-run start ignored
        ma = N_IN'($urandom); mb = N_IN'($urandom); cc = 2'($urandom);
        model(40, esig, eones);
        n_inputs = 5'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        wait_vec(5, "clamp_pre");
        n_inputs = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(40, "clamp_run");
        chk("clamp_busy", 64'(busy), 64'(1));
        chk("clamp_no_done", 64'(saw_done), 64'(0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("clamp_abort_idx", 64'(vec_idx), 64'(40));
        chk("clamp_sig", 64'(signature), 64'(esig));
        chk("clamp_ones", 64'(ones_count), 64'(eones));
        chk("clamp_abort_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
